vending_fsm_param: RTL and testbench
====================================

# vending_fsm_param

Parametrised cola vending controller, successor to the single-coin `simple_fsm`. It accepts half-unit and one-unit coins, vends at a configurable price, and returns change as a serial pulse stream. It also supports cancel-and-refund. It sits between the debounced coin/key inputs and the LED/buzzer indicator logic of the vending demo.

## Interface
- `PRICE_UNITS`, default 5: cola price in half-unit coins (5 = 2.5 yuan). Legal range is 1 to 2^CNT_W−4.
- `CNT_W`, default 4: width of the credit and change counters.

- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `pi_money_half`  in  1  one half-unit coin this cycle (value 1).
- `pi_money_one`  in  1  one full-unit coin this cycle (value 2).
- `pi_cancel`  in  1  refund request, single-cycle.
- `po_cola`  out  1  vend pulse, one cycle per cola.
- `po_change`  out  1  one cycle high per half-unit of change/refund returned.
- `po_busy`  out  1  high while in CHANGE; coins are not accepted.
- `po_credit`  out  CNT_W  current accumulated credit in half-units.

## Operation
- Internal registers are state (COLLECT, CHANGE), `credit` (CNT_W) and `change_cnt` (CNT_W). All outputs are registered.
- Coin value per cycle: add = pi_money_half + 2·pi_money_one. It ranges 0..3; both coins in one cycle add 3.
- Priority in COLLECT, highest first:
  - `pi_cancel`:
    - Let refund = credit + add.
    - If refund > 0: load change_cnt = refund, clear credit, go to CHANGE.
    - If refund = 0: no action.
    - Cancel always beats a vend in the same cycle.
  - credit + add ≥ PRICE_UNITS:
    - Set po_cola ← 1 and credit ← 0.
    - change = credit + add − PRICE_UNITS, which is 0..2.
    - If change > 0: change_cnt ← change and go to CHANGE. Otherwise stay in COLLECT.
  - Otherwise: credit ← credit + add.
- CHANGE:
  - Each cycle: po_change ← 1 and change_cnt ← change_cnt − 1.
  - When change_cnt = 1, go to COLLECT.
  - Coins and cancel presented in CHANGE are ignored. They are not credited and not queued.
- Arithmetic:
  - The sum credit + add is computed CNT_W+1 bits wide.
  - The parameter range guarantees the maximum sum (PRICE_UNITS+2) fits in CNT_W bits, so there is no wrap.
- Reset values: state = COLLECT; credit = 0; change_cnt = 0; po_cola = po_change = po_busy = 0; po_credit = 0.
- Reset mid-CHANGE aborts the refund. Pending change is discarded with no further po_change pulses. Reset has priority over every input.

## Timing
- A coin sampled at edge E appears in po_credit after E, i.e. 1-cycle latency.
- Vend at edge E: po_cola is high for exactly the cycle E..E+1, and po_credit reads 0 after E.
- Change of C units after a vend or cancel at edge E:
  - po_busy is high for cycles E..E+C.
  - po_change is high for cycles E+1..E+C+1, exactly C consecutive cycles, the first coincident with po_cola falling.
- po_busy falls one cycle before the last po_change pulse ends. A coin is accepted again at the first edge where po_busy is sampled low.
- po_cola and po_change never need to be high in the same cycle. Back-to-back vends with zero change are allowed on consecutive cycles.
- Conservation invariant: total coin value accepted = PRICE_UNITS × (po_cola count) + (po_change count) + po_credit.

## Test plan
All scenarios use PRICE_UNITS=5, CNT_W=4.

- **Five half coins on cycles 1..5:** po_credit steps 1,2,3,4, then po_cola pulses 1 cycle after cycle 5. po_credit = 0, no po_change, po_busy stays 0.
- **Three one-unit coins:** po_credit 2,4, then po_cola after the third coin. Change is 1: po_busy for 1 cycle, then exactly 1 po_change pulse.
- **Credit 4, then half and one together:** sum is 7, so po_cola plus 2 po_change pulses on consecutive cycles. A coin inserted during po_busy is ignored: final po_credit = 0.
- **Credit 3, then pi_cancel:** no po_cola, 3 po_change pulses, po_credit = 0. A cancel with credit 0 produces no output activity. Cancel together with a coin that would reach price (credit 4 + one) gives a refund of 6 pulses and no cola.
- **sys_rst asserted after 1 of 3 refund pulses:** next cycle all outputs are 0 and state is COLLECT. No further pulses appear, and a new half coin gives po_credit = 1.
- **10,000 random cycles of coin/cancel stimulus with a scoreboard:** the conservation invariant holds every cycle, po_credit never exceeds 4 in COLLECT, and po_cola is never longer than 1 cycle.

Source files
------------

// File: rtl/vending_fsm_param.sv
// ---------------------------------------------------------------------------
// vending_fsm_param
//
// Parametrised cola vending controller. Accepts half-unit (value 1) and
// one-unit (value 2) coins, vends once credit reaches PRICE_UNITS, and
// returns change or a cancel refund as a serial stream of po_change pulses,
// one pulse per half-unit.
//
// Parameters
//   PRICE_UNITS  price in half-units, legal range 1 .. 2**CNT_W-4
//   CNT_W        width of the credit and change counters
//
// Ports
//   sys_clk        in   system clock, rising edge
//   sys_rst        in   synchronous active-high reset
//   pi_money_half  in   half-unit coin this cycle
//   pi_money_one   in   one-unit coin this cycle
//   pi_cancel      in   single-cycle refund request
//   po_cola        out  one-cycle vend pulse
//   po_change      out  one pulse per half-unit of change/refund
//   po_busy        out  high while change is being paid out
//   po_credit      out  accumulated credit in half-units
// ---------------------------------------------------------------------------
module vending_fsm_param #(
    parameter int unsigned PRICE_UNITS = 5,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             pi_money_half,
    input  logic             pi_money_one,
    input  logic             pi_cancel,
    output logic             po_cola,
    output logic             po_change,
    output logic             po_busy,
    output logic [CNT_W-1:0] po_credit
);

    localparam int unsigned      SUM_W   = CNT_W + 1;
    localparam logic [SUM_W-1:0] PRICE_S = SUM_W'(PRICE_UNITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_CHANGE  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0] change_cnt_q, change_cnt_d;
    logic             cola_q, cola_d;
    logic             change_q, change_d;
    logic             busy_q, busy_d;

    // Coin value this cycle: half counts 1, one counts 2, both together 3.
    logic [1:0]       add_c;
    logic [SUM_W-1:0] sum_c;
    logic [CNT_W-1:0] refund_c;
    logic [CNT_W-1:0] vend_change_c;
    logic             cancel_go_c;
    logic             vend_go_c;

    assign add_c = {pi_money_one, pi_money_half};

    // One extra bit so the price comparison never sees a wrapped sum.
    assign sum_c = {1'b0, credit_q} + SUM_W'(add_c);

    // The parameter range keeps the largest sum (PRICE_UNITS+2) within CNT_W.
    assign refund_c      = CNT_W'(sum_c);
    assign vend_change_c = CNT_W'(sum_c - PRICE_S);

    // Cancel wins over a vend; a cancel with nothing to refund is a no-op.
    assign cancel_go_c = pi_cancel && (sum_c != '0);
    assign vend_go_c   = !pi_cancel && (sum_c >= PRICE_S);

    // State and datapath registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_COLLECT;
            credit_q     <= CNT_ZERO;
            change_cnt_q <= CNT_ZERO;
            cola_q       <= 1'b0;
            change_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            change_cnt_q <= change_cnt_d;
            cola_q       <= cola_d;
            change_q     <= change_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: begin
                if (cancel_go_c) begin
                    state_d = ST_CHANGE;
                end else if (vend_go_c && (vend_change_c != CNT_ZERO)) begin
                    state_d = ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                // Last pulse is being issued this cycle; a zero count is a
                // defensive exit so the FSM can never stick in CHANGE.
                if (change_cnt_q <= CNT_ONE) begin
                    state_d = ST_COLLECT;
                end
            end
        endcase
    end

    // Datapath and output logic; every output is captured in a flop.
    always_comb begin
        credit_d     = credit_q;
        change_cnt_d = change_cnt_q;
        cola_d       = 1'b0;
        change_d     = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (cancel_go_c) begin
                    change_cnt_d = refund_c;
                    credit_d     = CNT_ZERO;
                end else if (vend_go_c) begin
                    cola_d       = 1'b1;
                    credit_d     = CNT_ZERO;
                    change_cnt_d = vend_change_c;
                end else if (!pi_cancel) begin
                    credit_d     = refund_c;
                end
            end
            ST_CHANGE: begin
                // Coins and cancel are ignored while paying out.
                if (change_cnt_q != CNT_ZERO) begin
                    change_d     = 1'b1;
                    change_cnt_d = change_cnt_q - CNT_ONE;
                end
            end
        endcase
        busy_d = (state_d == ST_CHANGE);
    end

    assign po_cola   = cola_q;
    assign po_change = change_q;
    assign po_busy   = busy_q;
    assign po_credit = credit_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// ---------------------------------------------------------------------------
// tb_vending_fsm_param
//
// Scoreboard bench for vending_fsm_param (PRICE_UNITS=5, CNT_W=4). A
// timeline reference model schedules the expected cola/change pulses by
// absolute edge number and the expected credit/busy after each edge; a
// negedge monitor pops and compares whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_vending_fsm_param;

    localparam int unsigned PRICE = 5;
    localparam int unsigned CW    = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          pi_money_half = 1'b0;
    logic          pi_money_one  = 1'b0;
    logic          pi_cancel     = 1'b0;
    logic          po_cola;
    logic          po_change;
    logic          po_busy;
    logic [CW-1:0] po_credit;

    vending_fsm_param #(
        .PRICE_UNITS (PRICE),
        .CNT_W       (CW)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .pi_money_half (pi_money_half),
        .pi_money_one  (pi_money_one),
        .pi_cancel     (pi_cancel),
        .po_cola       (po_cola),
        .po_change     (po_change),
        .po_busy       (po_busy),
        .po_credit     (po_credit)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int cyc;
        bit cola;
    } ev_t;

    typedef struct {
        int cred;
        bit busy;
    } st_t;

    ev_t evq[$];
    st_t stq[$];

    int checks     = 0;
    int failures   = 0;
    int edge_cnt   = 0;
    int m_credit   = 0;
    int accept_from = 0;
    int accepted   = 0;
    int dut_cola   = 0;
    int dut_chg    = 0;
    bit reset_seen = 1'b0;
    bit mon_en     = 1'b1;

    // Reference model: plain arithmetic over an absolute edge timeline.
    task automatic model_step(input bit h, input bit o, input bit c, input bit r);
        int t;
        int add;
        int sum;
        int ch;
        ev_t e;
        st_t s;
        t = edge_cnt;
        if (r) begin
            m_credit    = 0;
            evq.delete();
            accept_from = t + 1;
            accepted    = 0;
            reset_seen  = 1'b1;
            s.cred = 0;
            s.busy = 1'b0;
            stq.push_back(s);
            return;
        end
        if (t >= accept_from) begin
            add = int'(h) + 2 * int'(o);
            sum = m_credit + add;
            if (c) begin
                if (sum > 0) begin
                    accepted += add;
                    for (int k = 1; k <= sum; k++) begin
                        e.cyc = t + k;
                        e.cola = 1'b0;
                        evq.push_back(e);
                    end
                    accept_from = t + sum + 1;
                    m_credit = 0;
                end
            end else if (sum >= int'(PRICE)) begin
                accepted += add;
                e.cyc = t;
                e.cola = 1'b1;
                evq.push_back(e);
                ch = sum - int'(PRICE);
                for (int k = 1; k <= ch; k++) begin
                    e.cyc = t + k;
                    e.cola = 1'b0;
                    evq.push_back(e);
                end
                accept_from = t + ch + 1;
                m_credit = 0;
            end else begin
                accepted += add;
                m_credit = sum;
            end
        end
        s.cred = m_credit;
        s.busy = (t + 1 < accept_from);
        stq.push_back(s);
    endtask

    task automatic drive(input bit h, input bit o, input bit c, input bit r);
        pi_money_half = h;
        pi_money_one  = o;
        pi_cancel     = c;
        sys_rst       = r;
        @(posedge sys_clk);
        edge_cnt++;
        model_step(h, o, c, r);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic monitor_cycle();
        int t;
        st_t s;
        t = edge_cnt;
        if (reset_seen) begin
            dut_cola   = 0;
            dut_chg    = 0;
            reset_seen = 1'b0;
        end
        checks++;
        if (stq.size() == 0) begin
            failures++;
            $display("FAIL state_queue edge=%0d got no expectation", t);
        end else begin
            s = stq.pop_front();
            if (po_credit !== CW'(s.cred) || po_busy !== s.busy) begin
                failures++;
                $display("FAIL credit_busy edge=%0d got credit=%0d busy=%b want credit=%0d busy=%b",
                         t, po_credit, po_busy, s.cred, s.busy);
            end
        end
        while (evq.size() > 0 && evq[0].cyc < t) begin
            checks++;
            failures++;
            $display("FAIL missing_pulse edge=%0d got none want %s at edge %0d",
                     t, evq[0].cola ? "cola" : "change", evq[0].cyc);
            void'(evq.pop_front());
        end
        if (po_cola === 1'b1) begin
            dut_cola++;
            checks++;
            if (evq.size() > 0 && evq[0].cyc == t && evq[0].cola) void'(evq.pop_front());
            else begin
                failures++;
                $display("FAIL cola_pulse edge=%0d got po_cola=1 want 0", t);
            end
        end
        if (po_change === 1'b1) begin
            dut_chg++;
            checks++;
            if (evq.size() > 0 && evq[0].cyc == t && !evq[0].cola) void'(evq.pop_front());
            else begin
                failures++;
                $display("FAIL change_pulse edge=%0d got po_change=1 want 0", t);
            end
        end
        if (evq.size() > 0 && evq[0].cyc == t) begin
            checks++;
            failures++;
            $display("FAIL pulse_absent edge=%0d got 0 want %s=1", t, evq[0].cola ? "po_cola" : "po_change");
            void'(evq.pop_front());
        end
        // Once payout is finished every accepted half-unit is accounted for.
        if (po_busy === 1'b0) begin
            checks++;
            if (accepted != int'(PRICE) * dut_cola + dut_chg + int'(po_credit)) begin
                failures++;
                $display("FAIL conservation edge=%0d got %0d*cola+%0d+credit %0d want accepted=%0d",
                         t, PRICE, dut_chg, po_credit, accepted);
            end
        end
        checks++;
        if (int'(po_credit) > int'(PRICE) - 1) begin
            failures++;
            $display("FAIL credit_limit edge=%0d got %0d want <= %0d", t, po_credit, PRICE - 1);
        end
    endtask

    initial begin
        forever begin
            @(negedge sys_clk);
            if (mon_en && edge_cnt > 0) monitor_cycle();
        end
    end

    initial begin
        // Reset
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        // Five half coins
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Three one-unit coins: vend with one unit of change
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        // Credit 4, then both coins: vend plus two change, coin during busy ignored
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        // Credit 3 then cancel
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        // Cancel with zero credit
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        // Credit 4, then cancel together with a one-unit coin: refund 6
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(8);
        // Reset after one of three refund pulses
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Random coin/cancel traffic with occasional reset
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 999) == 0));
        end
        idle(10);
        @(negedge sys_clk);
        #1;
        mon_en = 1'b0;
        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("FAIL leftover_pulses got %0d pending want 0", evq.size());
        end
        checks++;
        if (stq.size() != 0) begin
            failures++;
            $display("FAIL leftover_states got %0d pending want 0", stq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
